// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: requester ports and SD command host handshake.
// master: sequencer side (requests and host status in; commands, REQ/ACK and results out).
// slave: requester and host side (the mirror of master).
interface sd_cmd_sequencer_if;
    logic [1:0]  req_i;
    logic [39:0] cmd0_i;
    logic [15:0] set0_i;
    logic [39:0] cmd1_i;
    logic [15:0] set1_i;
    logic [1:0]  done_o;
    logic [39:0] resp_o;
    logic [7:0]  resp_status_o;
    logic        busy_o;
    logic [39:0] host_cmd_o;
    logic [15:0] host_set_o;
    logic        host_req_o;
    logic        host_ack_o;
    logic        host_ack_i;
    logic        host_req_i;
    logic [7:0]  host_status_i;
    logic [39:0] host_resp_i;
    logic        host_rst_o;

    modport master (
        input  req_i, cmd0_i, set0_i, cmd1_i, set1_i,
        input  host_ack_i, host_req_i, host_status_i, host_resp_i,
        output done_o, resp_o, resp_status_o, busy_o,
        output host_cmd_o, host_set_o, host_req_o, host_ack_o, host_rst_o
    );

    modport slave (
        output req_i, cmd0_i, set0_i, cmd1_i, set1_i,
        output host_ack_i, host_req_i, host_status_i, host_resp_i,
        input  done_o, resp_o, resp_status_o, busy_o,
        input  host_cmd_o, host_set_o, host_req_o, host_ack_o, host_rst_o
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: round-robin two-port front end for the SD command serial host.
// SD_CLK_IN clock; RST_IN asynchronous active-high reset.
// bus (master): req_i/cmdN_i/setN_i in, done_o/resp_o/resp_status_o/busy_o out;
// host_cmd_o/host_set_o/host_req_o/host_ack_o/host_rst_o drive the host,
// host_ack_i/host_req_i/host_status_i/host_resp_i come back from it.
module sd_cmd_sequencer #(
    parameter int TIMEOUT     = 4096,
    parameter int INIT_WAIT   = 80,
    parameter int HRST_CYCLES = 4
) (
    input  logic SD_CLK_IN,
    input  logic RST_IN,
    sd_cmd_sequencer_if.master bus
);
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, ACK, COOL, HRST} state_t;
    state_t      state, state_n;
    logic [15:0] cnt, tmo;
    logic        port, prio, gport, grant, tmo_hit, fin, ackd;
    logic        unused_st;
    assign unused_st = ^{bus.host_status_i[7], bus.host_status_i[4]};
    always_ff @(posedge SD_CLK_IN or posedge RST_IN)
        if (RST_IN) state <= INIT;
        else state <= state_n;
    always_comb begin
        gport   = (bus.req_i == 2'b11) ? prio : bus.req_i[1];
        grant   = state == IDLE && bus.req_i != 2'b00 && bus.host_ack_i;
        tmo_hit = (state == ISSUE || state == WAIT || state == ACK) && tmo == 16'(TIMEOUT - 1);
        // only the final REQ_OUT phase (STATUS[6]) is acknowledged
        fin     = state == WAIT && bus.host_req_i && bus.host_status_i[6];
        ackd    = state == ACK && bus.host_ack_i;
        state_n = state;
        if (tmo_hit) state_n = HRST;
        else
            case (state)
                INIT:    state_n = cnt == 16'(INIT_WAIT - 1) ? IDLE : INIT;
                IDLE:    state_n = grant ? ISSUE : IDLE;
                ISSUE:   state_n = bus.host_ack_i ? ISSUE : WAIT;
                WAIT:    state_n = fin ? ACK : WAIT;
                ACK:     state_n = ackd ? COOL : ACK;
                COOL:    state_n = cnt == 16'd2 ? IDLE : COOL;
                HRST:    state_n = cnt == 16'(HRST_CYCLES - 1) ? INIT : HRST;
                default: state_n = INIT;
            endcase
    end
    always_ff @(posedge SD_CLK_IN or posedge RST_IN)
        if (RST_IN) begin
            cnt               <= '0;
            tmo               <= '0;
            port              <= 1'b0;
            prio              <= 1'b0;
            bus.done_o        <= '0;
            bus.resp_o        <= '0;
            bus.resp_status_o <= '0;
            bus.busy_o        <= 1'b0;
            bus.host_cmd_o    <= '0;
            bus.host_set_o    <= '0;
            bus.host_req_o    <= 1'b0;
            bus.host_ack_o    <= 1'b0;
            bus.host_rst_o    <= 1'b0;
        end else begin
            bus.done_o <= 2'b00;
            bus.busy_o <= state_n != IDLE;
            // cnt times the INIT, COOL and HRST dwell, restarting on every state change
            cnt        <= state_n != state ? 16'd0 : cnt + 16'd1;
            tmo        <= grant ? 16'd0 : tmo + 16'd1;
            if (grant) begin
                bus.host_cmd_o <= gport ? bus.cmd1_i : bus.cmd0_i;
                bus.host_set_o <= gport ? bus.set1_i : bus.set0_i;
                bus.host_req_o <= 1'b1;
                port           <= gport;
            end
            if (tmo_hit) begin
                bus.resp_status_o <= 8'h80;
                bus.host_req_o    <= 1'b0;
                bus.host_ack_o    <= 1'b0;
                bus.host_rst_o    <= 1'b1;
                bus.done_o        <= {port, ~port};
                prio              <= ~port;
            end else begin
                if (state == ISSUE && !bus.host_ack_i) bus.host_req_o <= 1'b0;
                if (fin) begin
                    bus.resp_o        <= bus.host_resp_i;
                    // crc_ok is only meaningful for a read (STATUS = 6)
                    bus.resp_status_o <= {2'b01,
                                          bus.host_status_i[3:0] == 4'b0110 ? bus.host_status_i[5] : 1'b1,
                                          1'b0, bus.host_status_i[3:0]};
                    bus.host_ack_o    <= 1'b1;
                end
                if (ackd) begin
                    bus.host_ack_o <= 1'b0;
                    bus.done_o     <= {port, ~port};
                    prio           <= ~port;
                end
            end
            if (state == HRST && state_n == INIT) bus.host_rst_o <= 1'b0;
        end
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Two-port arbiter and handshake sequencer sitting in front of the SD command serial host. It accepts 40-bit commands plus 16-bit settings words from a software register port (port 0) and a DMA/data-master port (port 1), and grants one at a time using round-robin. It runs the full REQ/ACK exchange with the serial host and returns the response and status to the granted requester. On a stalled command it times out and soft-resets the serial host.

Parameters:
TIMEOUT, 4096, cycles from grant to final status before timeout (counter is 16 bits; must be < 65536)
INIT_WAIT, 80, cycles to wait after any reset before the host is usable (covers the host INIT delay of 64 plus margin)
HRST_CYCLES, 4, width of the host soft-reset pulse

Ports:
SD_CLK_IN  in  1  clock
RST_IN  in  1  asynchronous reset, active-high
req_i  in  2  per-port request, level; held until matching done pulse
cmd0_i  in  40  port-0 command (start/dir/index/argument)
set0_i  in  16  port-0 settings word (host SETTING_IN format)
cmd1_i  in  40  port-1 command
set1_i  in  16  port-1 settings word
done_o  out  2  one-hot, 1-cycle completion pulse to the granted port
resp_o  out  40  response captured from the host
resp_status_o  out  8  [3:0] final host STATUS[3:0]; [5] crc_ok; [6] complete; [7] timeout; [4] 0
busy_o  out  1  high in every state except IDLE
host_cmd_o  out  40  drives host CMD_IN
host_set_o  out  16  drives host SETTING_IN
host_req_o  out  1  drives host REQ_IN
host_ack_o  out  1  drives host ACK_IN
host_ack_i  in  1  host ACK_OUT
host_req_i  in  1  host REQ_OUT
host_status_i  in  8  host STATUS
host_resp_i  in  40  host CMD_OUT
host_rst_o  out  1  soft reset to host, ORed externally with RST_IN

Behaviour:
- Reset values: all outputs 0; state = INIT; round-robin pointer = 0, meaning port 0 has priority first.
- INIT: counts INIT_WAIT cycles, then goes to IDLE. Also entered after HRST.
- IDLE: if req_i != 0 and host_ack_i == 1, grant.
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins.
- On grant: latch cmd/set into host_cmd_o/host_set_o (stable until next grant), record the granted port, clear the timeout counter, then go to ISSUE.
- ISSUE: host_req_o = 1 until host_ack_i == 0 is sampled. This takes about 3 cycles because of the host's 2-flop synchronizer. On that edge host_req_o <= 0 and the state goes to WAIT.
- WAIT: on any cycle with host_req_i == 1 and host_status_i[6] == 1, this is the final status:
  - capture resp_o <= host_resp_i;
  - capture resp_status_o[3:0] <= host_status_i[3:0];
  - crc_ok <= host_status_i[5] when STATUS[3:0] = 4'b0110 (read), else 1;
  - complete <= 1, timeout <= 0;
  - host_ack_o <= 1; go to ACK.
- Intermediate REQ_OUT phases (status[6] == 0) are ignored and never acked. Acking early would advance the host past DLY_READ.
- ACK: hold host_ack_o = 1 until host_ack_i == 1. Then host_ack_o <= 0, pulse done_o for the granted port, and go to COOL.
- COOL: 3 cycles with everything idle so the host's synchronized ACK clears, then IDLE. The round-robin pointer updates on the done pulse.
- Timeout: a 16-bit counter runs in ISSUE/WAIT/ACK. When it reaches TIMEOUT:
  - resp_status_o <= 8'h80, resp_o unchanged;
  - deassert host_req_o/host_ack_o;
  - pulse done_o for the granted port;
  - go to HRST.
- HRST: host_rst_o = 1 for HRST_CYCLES, then INIT (full INIT_WAIT).
- A requester dropping req_i mid-operation is ignored. The command completes and its done_o still pulses.
- A new req_i arriving mid-operation is held off until IDLE.
- resp_o/resp_status_o stay valid from done_o until the next completion.
- host_ack_i low in IDLE (host not ready): no grant, no timeout.
- RST_IN mid-operation: immediate return to reset values and INIT. No done_o is issued.

Test Plan:
1. Port 0, set0_i=16'h0030 (48-bit response), host model returns STATUS=8'h66 with CMD_OUT=40'h3F_1234_5678 -> resp_o=40'h3F12345678, resp_status_o=8'h66, done_o=2'b01 one cycle, host_ack_o drops after host_ack_i rises.
2. Port 1, set1_i=16'h0000 (write-only), host gives STATUS=8'h44 -> resp_status_o=8'h64 (crc_ok forced 1), done_o=2'b10, no ack before STATUS[6].
3. Both ports request continuously for 4 commands -> grant order 0,1,0,1; next host_req_o never rises before COOL ends.
4. Read with CRC failure, STATUS=8'h46 -> resp_status_o=8'h46 (crc_ok=0), done_o pulses normally.
5. Host never answers (TIMEOUT=64 in bench) -> done_o pulses at cycle 64 after grant, resp_status_o=8'h80, host_rst_o high 4 cycles, busy_o high until INIT_WAIT completes.
6. Request at cycle 5 after RST_IN release -> no host_req_o before cycle INIT_WAIT (80). Assert RST_IN during WAIT -> all outputs 0 next edge, no done_o.
